gigex_rx_cmd_decoder: RTL and testbench
=======================================

Name: gigex_rx_cmd_decoder

Overview:
- Receive-side counterpart of the ethernet TX controller. Accepts the GigEx Rx byte stream (Q/nRx/RC) and drives the per-channel Rx-FIFO-full flags (nRF).
- Packs bytes on one configured channel into 32-bit command words, MSB byte first, and buffers the words in a small FIFO.
- Routes each word, by its module-id field, to one of NMODULES valid/ready command streams that feed the per-module reset/tx command path.
- Runs entirely in the eth_clk (125 MHz) domain.

Parameters:
- NMODULES, 4, number of frontend modules and output streams.
- CMD_LEN, 32, command word width; must be a multiple of 8.
- CHANNEL, 0, the only GigEx channel accepted (0-7).
- FIFO_DEPTH, 16, command FIFO depth in words; power of 2.
- SKID, 2, free-word headroom kept in the FIFO when nRF signals full.
- TIMEOUT, 255, idle cycles after which a partial word is discarded.

Ports:
- clk  in  1  eth_clk.
- rst  in  1  asynchronous reset, active-high.
- Q  in  8  Rx data byte from GigEx.
- nRx  in  1  Rx byte valid, active low.
- RC  in  3  Rx byte channel.
- nRF  out  8  per-channel Rx FIFO full flag to GigEx, active low.
- cmd_data  out  CMD_LEN  command word, shared by all streams.
- cmd_valid  out  NMODULES  one-hot valid, one bit per module.
- cmd_ready  in  NMODULES  per-module ready.
- drop_count  out  16  saturating count of discarded words and bytes.

Behaviour:
- **Byte acceptance:** a byte is taken at a posedge when nRx==0 and RC==CHANNEL.
  - Bytes with nRx==0 and RC!=CHANNEL are discarded; drop_count +1.
- **Assembler:**
  - Shift register of CMD_LEN-8 bits plus byte counter bcnt, 0..CMD_LEN/8-1.
  - First byte received becomes cmd_data[CMD_LEN-1:CMD_LEN-8].
  - On the final byte, {shift, Q} is written into the FIFO on that same edge and bcnt wraps to 0.
- **Timeout:** an idle counter resets on every accepted byte. If bcnt!=0 and the counter reaches TIMEOUT, the partial word is discarded, bcnt clears and drop_count +1. This resynchronises word framing.
- **FIFO:** synchronous, first-word-fall-through, count-based.
  - The head word is visible on cmd_data 1 cycle after its final byte edge.
  - A write when the FIFO is full discards the word; drop_count +1. The FIFO contents are unchanged.
  - Simultaneous push and pop while full: the pop frees a slot, so the push succeeds.
- **Flow control (registered):**
  - nRF[CHANNEL] = 0 (full) when count >= FIFO_DEPTH-SKID; otherwise 1.
  - All other nRF bits are held at 1, so GigEx drains those channels into the discard path.
- **Routing:** id = cmd_data[CMD_LEN-1 -: 4].
  - If FIFO non-empty and id<NMODULES: cmd_valid[id]=1, all other bits 0.
  - Pop on cmd_valid[id] & cmd_ready[id].
  - While valid and not ready, cmd_data and cmd_valid are held stable (AXI-stream rules). There is no reordering and there is head-of-line blocking.
  - If id>=NMODULES: cmd_valid stays 0, the head word is popped on that cycle and drop_count +1.
- **drop_count:** saturates at 16'hFFFF. Simultaneous drop events in one cycle all count (maximum +3 per cycle).
- **Reset (asynchronous):**
  - nRF=8'h00 (all channels full, GigEx held off).
  - cmd_valid=0, cmd_data=0, drop_count=0.
  - FIFO emptied, bcnt=0, idle counter=0.
  - First edge after release: nRF becomes 8'hFF.
  - Reset during a partial word or a pending handshake loses that data silently and does not count it.

Decomposition:
- Shared package **gigex_cmd_pkg**:
  - CMD_LEN.
  - MODULE_ID_WIDTH=4, MODULE_ID_OFFSET=CMD_LEN-1.
  - GigEx channel constants.
  - The command-word type, reused by the reset controller.
- One sub-module, **cmd_sync_fifo**:
  - Parameters: WIDTH, DEPTH.
  - Outputs: fwft dout, empty, full, count.
  - Same asynchronous active-high reset as this block.

Test Plan:
- **Basic routing:** 4 bytes 0x2A,0xBC,0xDE,0xF0 on channel 0 in consecutive cycles → 1 cycle after the last byte, cmd_valid=4'b0100 and cmd_data=0x2ABCDEF0; popped when cmd_ready[2]=1.
- **Bad module id:** word 0x7000_0001 → no cmd_valid asserted, word popped, drop_count=1.
- **Wrong channel:** 3 bytes with RC=3 → ignored, drop_count=3, bcnt unchanged, nRF[3] stays 1.
- **Backpressure:** cmd_ready=0, 14 words pushed → nRF[0] goes 0 one cycle after count reaches 14. Push a 17th word when full → drop_count +1, contents of words 1-16 intact. Release ready → words 1-16 drain in order.
- **Timeout:** 2 bytes then 255 idle cycles → partial word discarded, drop_count=1. The next 4 bytes form a correct word.
- **Reset mid-operation:** assert rst after 2 bytes with 3 words queued → nRF=0x00 and cmd_valid=0 immediately. After release, nRF=0xFF and the next 4 bytes form a correct word.

Source files
------------

// File: rtl/gigex_cmd_pkg.sv
// gigex_cmd_pkg: shared GigEx channel and command-word definitions
package gigex_cmd_pkg;
    localparam int CMD_LEN          = 32;
    localparam int MODULE_ID_WIDTH  = 4;
    localparam int MODULE_ID_OFFSET = CMD_LEN - 1;
    localparam int GIGEX_CHANNELS   = 8;
    localparam int GIGEX_CH_WIDTH   = 3;
    typedef logic [CMD_LEN-1:0] cmd_word_t;
endpackage

// File: rtl/cmd_sync_fifo.sv
// cmd_sync_fifo: count-based first-word-fall-through synchronous FIFO
module cmd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic push, pop;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign pop   = rd_en & ~empty;
    assign push  = wr_en & (~full | pop);
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign dout  = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + 1'b1 : wp;
            rp    <= pop ? rp + 1'b1 : rp;
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/gigex_rx_cmd_decoder.sv
// gigex_rx_cmd_decoder: packs GigEx Rx bytes into command words and routes
// them by module id to per-module valid/ready streams
module gigex_rx_cmd_decoder
    import gigex_cmd_pkg::*;
#(
    parameter int NMODULES   = 4,
    parameter int CMD_LEN    = gigex_cmd_pkg::CMD_LEN,
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int SKID       = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                Q,
    input  logic                      nRx,
    input  logic [GIGEX_CH_WIDTH-1:0] RC,
    output logic [GIGEX_CHANNELS-1:0] nRF,
    output logic [CMD_LEN-1:0]        cmd_data,
    output logic [NMODULES-1:0]       cmd_valid,
    input  logic [NMODULES-1:0]       cmd_ready,
    output logic [15:0]               drop_count
);
    localparam int NBYTES = CMD_LEN / 8;
    localparam int BW = $clog2(NBYTES);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [CMD_LEN-9:0] shift;
    logic [BW-1:0] bcnt;
    logic [IW-1:0] idle;
    logic [CMD_LEN-1:0] head;
    logic [CW-1:0] count;
    logic [MODULE_ID_WIDTH-1:0] id;
    logic [2:0] inc;
    logic accept, reject, last, timeout, push, pop, bad_id, full_drop, empty, full;
    assign accept    = ~nRx & (RC == GIGEX_CH_WIDTH'(CHANNEL));
    assign reject    = ~nRx & ~accept;
    assign last      = bcnt == BW'(NBYTES - 1);
    assign push      = accept & last;
    assign timeout   = ~accept & (bcnt != '0) & (idle == IW'(TIMEOUT - 1));
    assign id        = head[CMD_LEN-1 -: MODULE_ID_WIDTH];
    assign bad_id    = ~empty & ({1'b0, id} >= (MODULE_ID_WIDTH + 1)'(NMODULES));
    assign cmd_valid = (empty | bad_id) ? '0 : NMODULES'(1) << id;
    assign cmd_data  = empty ? '0 : head;
    // Unroutable words are popped immediately so they never block the queue
    assign pop       = bad_id | |(cmd_valid & cmd_ready);
    assign full_drop = push & full & ~pop;
    assign inc       = 3'(reject) + 3'(timeout) + 3'(full_drop) + 3'(bad_id);
    cmd_sync_fifo #(.WIDTH(CMD_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   ({shift, Q}),
        .rd_en (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shift <= '0;
            bcnt  <= '0;
            idle  <= '0;
        end else if (accept) begin
            shift <= {shift[CMD_LEN-17:0], Q};
            bcnt  <= last ? '0 : bcnt + 1'b1;
            idle  <= '0;
        end else if (timeout) begin
            bcnt <= '0;
            idle <= '0;
        end else if (bcnt != '0) begin
            idle <= idle + 1'b1;
        end
    // Unused channels always read as not-full so GigEx flushes them into the discard path
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            nRF        <= '0;
            drop_count <= '0;
        end else begin
            nRF          <= '1;
            nRF[CHANNEL] <= count < CW'(FIFO_DEPTH - SKID);
            drop_count   <= (17'(drop_count) + 17'(inc) > 17'hFFFF) ? 16'hFFFF : drop_count + 16'(inc);
        end
endmodule

// File: tb/tb_gigex_rx_cmd_decoder.sv
// tb_gigex_rx_cmd_decoder: directed and randomized checks against a queue-based model
module tb_gigex_rx_cmd_decoder;
    localparam int N = 4, CH = 0, D = 16, SK = 2, TO = 255;
    logic clk = 0, rst = 1, nRx = 1;
    logic [7:0] Q = 0, nRF;
    logic [2:0] RC = 0;
    logic [31:0] cmd_data;
    logic [3:0] cmd_valid, cmd_ready = 0;
    logic [15:0] drop_count;
    int tests = 0, fails = 0;
    logic [31:0] fq[$];
    logic [7:0] part[$];
    int mdrop = 0, midle = 0;
    logic [7:0] mnrf = 0;

    gigex_rx_cmd_decoder #(.NMODULES(N), .CMD_LEN(32), .CHANNEL(CH), .FIFO_DEPTH(D), .SKID(SK), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .Q(Q), .nRx(nRx), .RC(RC), .nRF(nRF),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .drop_count(drop_count)
    );

    always #4 clk = ~clk;

    // Reference behaviour for one clock edge, from the pre-edge inputs and state
    task automatic model_edge();
        bit pop = 0, push = 0;
        logic [31:0] w = 0;
        int id;
        mnrf = 8'hFF;
        if (fq.size() >= D - SK) mnrf[CH] = 1'b0;
        if (fq.size() > 0) begin
            id = int'(fq[0][31:28]);
            if (id >= N) begin pop = 1; mdrop++; end
            else if (cmd_ready[id]) pop = 1;
        end
        if (!nRx && RC == CH) begin
            part.push_back(Q);
            midle = 0;
            if (part.size() == 4) begin
                w = {part[0], part[1], part[2], part[3]};
                part.delete();
                if (fq.size() < D || pop) push = 1; else mdrop++;
            end
        end else begin
            if (!nRx) mdrop++;
            if (part.size() > 0) begin
                midle++;
                if (midle == TO) begin part.delete(); midle = 0; mdrop++; end
            end
        end
        if (pop) void'(fq.pop_front());
        if (push) fq.push_back(w);
        if (mdrop > 65535) mdrop = 65535;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [2:0] c);
        nRx = 0; Q = b; RC = c;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 3'(CH));
        nRx = 1;
    endtask

    task automatic reset_on();
        rst = 1; nRx = 1; cmd_ready = 0;
        fq.delete(); part.delete(); mdrop = 0; midle = 0; mnrf = 8'h00;
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();
    endtask

    task automatic do_reset();
        reset_on();
        reset_off();
    endtask

    task automatic test_reset();
        reset_on();
        #1;
        tests++; if (nRF !== 8'h00) begin fails++; $display("FAIL reset_nrf: got %h want 00", nRF); end
        tests++; if (cmd_valid !== 4'h0) begin fails++; $display("FAIL reset_valid: got %h want 0", cmd_valid); end
        tests++; if (cmd_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", cmd_data); end
        tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        reset_off();
        tests++; if (nRF !== 8'hFF) begin fails++; $display("FAIL reset_release_nrf: got %h want ff", nRF); end
    endtask

    task automatic test_basic_routing();
        do_reset();
        send_byte(8'h2A, 3'(CH)); send_byte(8'hBC, 3'(CH)); send_byte(8'hDE, 3'(CH)); send_byte(8'hF0, 3'(CH));
        nRx = 1;
        tests++; if (cmd_valid !== 4'b0100) begin fails++; $display("FAIL basic_valid: got %b want 0100", cmd_valid); end
        tests++; if (cmd_data !== 32'h2ABCDEF0) begin fails++; $display("FAIL basic_data: got %h want 2abcdef0", cmd_data); end
        tick();
        tests++; if (cmd_valid !== 4'b0100) begin fails++; $display("FAIL basic_hold: got %b want 0100", cmd_valid); end
        cmd_ready = 4'b0100;
        tick();
        cmd_ready = 0;
        tests++; if (cmd_valid !== 4'b0000) begin fails++; $display("FAIL basic_pop: got %b want 0000", cmd_valid); end
        tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL basic_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_bad_id();
        do_reset();
        send_word(32'h7000_0001);
        tests++; if (cmd_valid !== 4'b0000) begin fails++; $display("FAIL badid_valid: got %b want 0000", cmd_valid); end
        tick();
        tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL badid_drop: got %0d want 1", drop_count); end
        tests++; if (fq.size() != 0 || cmd_valid !== 4'b0000) begin fails++; $display("FAIL badid_popped: got valid %b want 0000", cmd_valid); end
    endtask

    task automatic test_wrong_channel();
        do_reset();
        send_byte(8'h11, 3'(CH));
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h80 + i), 3'd3);
            tests++; if (nRF[3] !== 1'b1) begin fails++; $display("FAIL wrongch_nrf3: got %b want 1", nRF[3]); end
        end
        nRx = 1;
        tick();
        tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL wrongch_drop: got %0d want 3", drop_count); end
        send_byte(8'h22, 3'(CH)); send_byte(8'h33, 3'(CH)); send_byte(8'h44, 3'(CH));
        nRx = 1;
        tests++; if (cmd_data !== 32'h11223344) begin fails++; $display("FAIL wrongch_data: got %h want 11223344", cmd_data); end
        tests++; if (cmd_valid !== 4'b0010) begin fails++; $display("FAIL wrongch_valid: got %b want 0010", cmd_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w[17];
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            w = $urandom;
            w[31:28] = 4'($urandom_range(0, N - 1));
            exp_w[i] = w;
        end
        for (int i = 0; i < 14; i++) send_word(exp_w[i]);
        tests++; if (nRF[0] !== 1'b1) begin fails++; $display("FAIL bp_nrf_at14: got %b want 1", nRF[0]); end
        tick();
        tests++; if (nRF[0] !== 1'b0) begin fails++; $display("FAIL bp_nrf_after14: got %b want 0", nRF[0]); end
        tests++; if (nRF[7:1] !== 7'h7F) begin fails++; $display("FAIL bp_nrf_others: got %h want 7f", nRF[7:1]); end
        for (int i = 14; i < 17; i++) send_word(exp_w[i]);
        tick();
        tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL bp_full_drop: got %0d want 1", drop_count); end
        cmd_ready = 4'hF;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (cmd_data !== exp_w[i] || cmd_valid !== 4'(1 << exp_w[i][31:28])) begin
                fails++; $display("FAIL bp_drain[%0d]: got %h/%b want %h", i, cmd_data, cmd_valid, exp_w[i]);
            end
            tick();
        end
        cmd_ready = 0;
        tests++; if (cmd_valid !== 4'b0000) begin fails++; $display("FAIL bp_empty: got %b want 0000", cmd_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h31, 3'(CH)); send_byte(8'h99, 3'(CH));
        nRx = 1;
        repeat (TO - 1) tick();
        tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL timeout_early: got %0d want 0", drop_count); end
        tick();
        tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL timeout_drop: got %0d want 1", drop_count); end
        send_word(32'h3123_4567);
        tests++; if (cmd_data !== 32'h31234567) begin fails++; $display("FAIL timeout_data: got %h want 31234567", cmd_data); end
        tests++; if (cmd_valid !== 4'b1000) begin fails++; $display("FAIL timeout_valid: got %b want 1000", cmd_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(32'h0111_1111); send_word(32'h1222_2222); send_word(32'h2333_3333);
        send_byte(8'h3A, 3'(CH)); send_byte(8'h3B, 3'(CH));
        nRx = 1;
        #2;
        reset_on();
        #1;
        tests++; if (nRF !== 8'h00) begin fails++; $display("FAIL midrst_nrf: got %h want 00", nRF); end
        tests++; if (cmd_valid !== 4'h0) begin fails++; $display("FAIL midrst_valid: got %b want 0000", cmd_valid); end
        reset_off();
        tests++; if (nRF !== 8'hFF) begin fails++; $display("FAIL midrst_release_nrf: got %h want ff", nRF); end
        send_word(32'h1CAF_E000);
        tests++; if (cmd_data !== 32'h1CAFE000) begin fails++; $display("FAIL midrst_data: got %h want 1cafe000", cmd_data); end
        tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_random();
        logic [3:0] ev;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            nRx = $urandom_range(0, 9) < 7 ? 1'b0 : 1'b1;
            RC = $urandom_range(0, 9) < 8 ? 3'(CH) : 3'($urandom_range(1, 7));
            Q = 8'($urandom);
            cmd_ready = ((c / 400) % 2) ? 4'($urandom) : 4'h0;
            tick();
            ev = 0;
            if (fq.size() > 0 && fq[0][31:28] < N) ev = 4'(1 << fq[0][31:28]);
            tests++; if (cmd_valid !== ev) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", c, cmd_valid, ev); end
            if (fq.size() > 0) begin
                tests++; if (cmd_data !== fq[0]) begin fails++; $display("FAIL rnd_data@%0d: got %h want %h", c, cmd_data, fq[0]); end
            end
            tests++; if (nRF !== mnrf) begin fails++; $display("FAIL rnd_nrf@%0d: got %h want %h", c, nRF, mnrf); end
            tests++; if (drop_count !== 16'(mdrop)) begin fails++; $display("FAIL rnd_drop@%0d: got %0d want %0d", c, drop_count, mdrop); end
        end
        nRx = 1;
        cmd_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_bad_id();
        test_wrong_channel();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
